byte_proc: RTL and testbench
============================

Name: byte_proc

Overview:
- Streaming read-modify-write engine for a word-addressed Avalon-MM memory.
- Reads `length_i` bytes starting at word `base_addr_i`, applies a per-byte operation selected at run time (add, subtract, xor or pass) with a byte operand, and writes the result back to the same addresses.
- Parametrised successor of the single-outstanding byte incrementer:
  - pipelined reads, with up to `MAX_OUTST` in flight;
  - internal read-data buffer;
  - selectable operation.
- Sits between the control/CSR logic and the memory interconnect. Read and write masters are separate.

Parameters:
- `DATA_WIDTH`, 64, bus data width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 10, word address width.
- `BYTE_CNT`, `DATA_WIDTH/8`, bytes per word.
- `MAX_OUTST`, 4, maximum outstanding reads. This is also the buffer depth; a power of 2, at least 2.

Ports:
- `clk_i`  in  1  single clock.
- `srst_i`  in  1  synchronous, active-high reset.
- `base_addr_i`  in  `ADDR_WIDTH`  first word address; sampled when `run_i` is accepted.
- `length_i`  in  `ADDR_WIDTH`  length in bytes; sampled when `run_i` is accepted.
- `op_i`  in  2  operation select: 0 ADD, 1 SUB, 2 XOR, 3 PASS; sampled when `run_i` is accepted.
- `operand_i`  in  8  byte operand; sampled when `run_i` is accepted.
- `run_i`  in  1  start pulse.
- `waitrequest_o`  out  1  busy indication.
- `amm_rd_address_o`  out  `ADDR_WIDTH`
- `amm_rd_read_o`  out  1
- `amm_rd_readdata_i`  in  `DATA_WIDTH`
- `amm_rd_readdatavalid_i`  in  1
- `amm_rd_waitrequest_i`  in  1
- `amm_wr_address_o`  out  `ADDR_WIDTH`
- `amm_wr_write_o`  out  1
- `amm_wr_writedata_o`  out  `DATA_WIDTH`
- `amm_wr_byteenable_o`  out  `BYTE_CNT`
- `amm_wr_waitrequest_i`  in  1

Behaviour:
- **Reset values:** all outputs are 0, the FSM is in IDLE, the buffer is empty and all counters are 0.
- **Job acceptance:** `run_i` is accepted only in IDLE and only when `length_i != 0`.
  - The inputs are latched on acceptance and `waitrequest_o` = 1 from the next cycle.
  - `run_i` while busy is ignored. `run_i` with length 0 is ignored and `waitrequest_o` stays 0.
- **Word count:** `words = min(ceil(len/BYTE_CNT), 2**ADDR_WIDTH - base)`, computed with `ADDR_WIDTH+1` bits.
  - Addresses never wrap; the job is truncated at the top address.
- **FSM:** IDLE -> ACTIVE on accept -> DONE when the last write is accepted -> IDLE the next cycle. `waitrequest_o` = 0 in IDLE only.
- **Read side (in ACTIVE):**
  - Issue a read while `issued < words` and `outstanding + buffer_count < MAX_OUTST` (credit check). The buffer therefore never overflows.
  - `address`/`read` are held stable while `amm_rd_waitrequest_i` = 1; `address` increments per accepted read.
  - Every `amm_rd_readdatavalid_i` pushes `readdata` into the buffer.
- **Write side:**
  - When the buffer is non-empty, present a write with the address `base + written`.
  - `writedata[8k+7:8k] = f(byte k, operand)`, where f is:
    - ADD: mod 256;
    - SUB: mod 256;
    - XOR;
    - PASS: unchanged.
  - Hold all write outputs while `amm_wr_waitrequest_i` = 1. Pop the buffer on acceptance.
  - `byteenable` is all ones, except:
    - the final word of an untruncated job with `len % BYTE_CNT = r != 0`, which gets the low r bits set;
    - a truncated final word, which stays all ones.
- **Throughput:** a read push and a write pop in the same cycle are both honoured, giving one word per cycle when there are no stalls.
- **Read latency:** arbitrary, including 0 extra cycles after acceptance.
- **Reset mid-operation:** aborts the job.
  - Outputs and counters return to their reset values.
  - The buffer is flushed; stale `readdatavalid` responses after reset are discarded. An outstanding counter cleared by reset ignores them.
  - The interconnect must not deliver responses for reads issued before reset. This is a system constraint.

Optional Feature:
- Macro `BYTE_PROC_SATURATE_EN`.
- Defined: ADD clamps at 0xFF and SUB clamps at 0x00.
- Undefined: ADD and SUB wrap mod 256. XOR and PASS are unaffected either way.

Decomposition:
- Package `byte_proc_pkg`:
  - `op_t` enum (ADD/SUB/XOR/PASS);
  - `state_t` enum (IDLE/ACTIVE/DONE);
  - an automatic function `byte_op(byte, operand, op)`, which contains the saturation ifdef.
- Sub-module `byte_proc_buf`:
  - synchronous show-ahead FIFO of `MAX_OUTST` x `DATA_WIDTH`;
  - ports push, pop, data in/out, count, empty, with synchronous reset.
- Top level holds the FSM, the counters, the credit logic and the byte mapping.

Test Plan:
1. base 0x10, len 21, op ADD, operand 1, no stalls, 0-cycle read latency -> 3 writes to 0x10..0x12; last byteenable 0x1F; every byte = read+1; `waitrequest_o` falls 1 cycle after the 3rd write is accepted.
2. Same job with random `rd_waitrequest`/`wr_waitrequest` and read latency 1-5 cycles -> identical data and addresses; `outstanding` never exceeds 4; no buffer overflow.
3. base 0x3FC, len 45 -> only 4 writes, to 0x3FC..0x3FF, all byteenables 0xFF, no wrap to 0x000.
4. Word 0x2F1EFF16FF12FFEE, len 7, ADD 1 -> 0x301F0017001300EF with byteenable 0x7F; with the macro defined -> 0x301FFF17FF13FFEF.
5. SUB 0x10 and XOR 0xA5 on random data, len 16 -> correct bytes; `run_i` asserted mid-job is ignored; `run_i` with len 0 leaves `waitrequest_o` at 0.
6. Assert `srst_i` after 2 writes of an 8-word job -> all outputs 0 next cycle; a new job of len 8 completes correctly.

Source files
------------

// File: rtl/byte_proc_pkg.sv
// byte_proc_pkg: operation/state encodings and the per-byte operation (BYTE_PROC_SATURATE_EN clamps ADD/SUB)
package byte_proc_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'd0,
      OP_SUB  = 2'd1,
      OP_XOR  = 2'd2,
      OP_PASS = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

   function automatic logic [7:0] byte_op(input logic [7:0] b, input logic [7:0] operand, input op_t op);
`ifdef BYTE_PROC_SATURATE_EN
      logic [8:0] sum;
      logic [8:0] diff;
      sum  = {1'b0, b} + {1'b0, operand};
      diff = {1'b0, b} - {1'b0, operand};
      return op == OP_ADD ? (sum[8] ? 8'hFF : sum[7:0]) :
             op == OP_SUB ? (diff[8] ? 8'h00 : diff[7:0]) :
             op == OP_XOR ? b ^ operand : b;
`else
      return op == OP_ADD ? b + operand :
             op == OP_SUB ? b - operand :
             op == OP_XOR ? b ^ operand : b;
`endif
   endfunction

endpackage

// File: rtl/byte_proc_buf.sv
// byte_proc_buf: show-ahead read-data FIFO between the read and write masters
module byte_proc_buf
   import byte_proc_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4
) (
   input  logic                     clk_i,
   input  logic                     srst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [DATA_WIDTH-1:0]    data_i,
   output logic [DATA_WIDTH-1:0]    data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o
);

   localparam int PW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [PW:0]           count_q;

   // Pointers and fill level; push and pop in the same cycle leave the level unchanged
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
      end
   end

   // Storage needs no reset: the head is only consumed when the level is non-zero
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = count_q == '0;

endmodule

// File: rtl/byte_proc.sv
// byte_proc: pipelined byte read-modify-write engine over Avalon-MM; BYTE_PROC_SATURATE_EN makes ADD/SUB saturate
module byte_proc
   import byte_proc_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 10,
   parameter int BYTE_CNT   = DATA_WIDTH / 8,
   parameter int MAX_OUTST  = 4
) (
   input  logic                  clk_i,
   input  logic                  srst_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH-1:0] length_i,
   input  logic [1:0]            op_i,
   input  logic [7:0]            operand_i,
   input  logic                  run_i,
   output logic                  waitrequest_o,
   output logic [ADDR_WIDTH-1:0] amm_rd_address_o,
   output logic                  amm_rd_read_o,
   input  logic [DATA_WIDTH-1:0] amm_rd_readdata_i,
   input  logic                  amm_rd_readdatavalid_i,
   input  logic                  amm_rd_waitrequest_i,
   output logic [ADDR_WIDTH-1:0] amm_wr_address_o,
   output logic                  amm_wr_write_o,
   output logic [DATA_WIDTH-1:0] amm_wr_writedata_o,
   output logic [BYTE_CNT-1:0]   amm_wr_byteenable_o,
   input  logic                  amm_wr_waitrequest_i
);

   localparam int CW = $clog2(MAX_OUTST) + 1;
   localparam logic [ADDR_WIDTH:0] SPAN = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                state_q, state_d;
   op_t                   op_q, op_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH:0]   words_q, words_d;
   logic [ADDR_WIDTH:0]   issued_q, issued_d;
   logic [ADDR_WIDTH:0]   written_q, written_d;
   logic [CW-1:0]         outst_q, outst_d;
   logic [BYTE_CNT-1:0]   be_last_q, be_last_d;
   logic [7:0]            operand_q, operand_d;

   logic [ADDR_WIDTH:0]   len_words, len_rem, room;
   logic [BYTE_CNT-1:0]   be_new;
   logic [CW-1:0]         buf_count;
   logic [DATA_WIDTH-1:0] head, mapped;
   logic                  accept, trunc, rd_req, wr_req, rd_go, wr_go, push, last, buf_empty;

   byte_proc_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MAX_OUTST)
   ) u_buf (
      .clk_i   (clk_i),
      .srst_i  (srst_i),
      .push_i  (push),
      .pop_i   (wr_go),
      .data_i  (amm_rd_readdata_i),
      .data_o  (head),
      .count_o (buf_count),
      .empty_o (buf_empty)
   );

   // Job geometry from the request: word count clipped at the top of memory, mask for a partial final word
   always_comb begin
      len_words = ({1'b0, length_i} + (ADDR_WIDTH+1)'(BYTE_CNT - 1)) / (ADDR_WIDTH+1)'(BYTE_CNT);
      len_rem   = {1'b0, length_i} % (ADDR_WIDTH+1)'(BYTE_CNT);
      room      = SPAN - {1'b0, base_addr_i};
      trunc     = len_words > room;
      be_new    = '1;
      for (int k = 0; k < BYTE_CNT; k++)
         if (!trunc && len_rem != '0 && (ADDR_WIDTH+1)'(k) >= len_rem) be_new[k] = 1'b0;
   end

   // A read is only issued when a buffer slot is guaranteed for its response
   assign accept = state_q == IDLE && run_i && length_i != '0;
   assign rd_req = state_q == ACTIVE && issued_q < words_q &&
                   ({1'b0, outst_q} + {1'b0, buf_count} < (CW+1)'(MAX_OUTST));
   assign wr_req = state_q == ACTIVE && !buf_empty;
   assign rd_go  = rd_req && !amm_rd_waitrequest_i;
   assign wr_go  = wr_req && !amm_wr_waitrequest_i;
   assign push   = amm_rd_readdatavalid_i && outst_q != '0;
   assign last   = written_q + ONE == words_q;

   // Next state, job registers and transfer counters
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      base_d    = base_q;
      words_d   = words_q;
      be_last_d = be_last_q;
      operand_d = operand_q;
      issued_d  = issued_q + (rd_go ? ONE : '0);
      written_d = written_q + (wr_go ? ONE : '0);
      outst_d   = outst_q + CW'(rd_go) - CW'(push);
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = ACTIVE;
               op_d      = op_t'(op_i);
               base_d    = base_addr_i;
               words_d   = trunc ? room : len_words;
               be_last_d = be_new;
               operand_d = operand_i;
               issued_d  = '0;
               written_d = '0;
               outst_d   = '0;
            end
         end
         ACTIVE: state_d = wr_go && last ? DONE : ACTIVE;
         default: state_d = IDLE;
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q   <= IDLE;
         op_q      <= OP_ADD;
         base_q    <= '0;
         words_q   <= '0;
         be_last_q <= '0;
         operand_q <= '0;
         issued_q  <= '0;
         written_q <= '0;
         outst_q   <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         base_q    <= base_d;
         words_q   <= words_d;
         be_last_q <= be_last_d;
         operand_q <= operand_d;
         issued_q  <= issued_d;
         written_q <= written_d;
         outst_q   <= outst_d;
      end
   end

   // Per-byte operation on the buffer head
   always_comb begin
      mapped = '0;
      for (int k = 0; k < BYTE_CNT; k++)
         mapped[8*k +: 8] = byte_op(head[8*k +: 8], operand_q, op_q);
   end

   // Bus outputs; everything reads zero while no request is presented
   always_comb begin
      waitrequest_o       = state_q != IDLE;
      amm_rd_read_o       = rd_req;
      amm_rd_address_o    = rd_req ? base_q + issued_q[ADDR_WIDTH-1:0] : '0;
      amm_wr_write_o      = wr_req;
      amm_wr_address_o    = wr_req ? base_q + written_q[ADDR_WIDTH-1:0] : '0;
      amm_wr_writedata_o  = wr_req ? mapped : '0;
      amm_wr_byteenable_o = !wr_req ? '0 : last ? be_last_q : '1;
   end

endmodule

// File: tb/tb_byte_proc.sv
// tb_byte_proc: table-driven jobs against a memory model with a write scoreboard
module tb_byte_proc;

   logic        clk = 1'b0;
   logic        srst_i = 1'b1;
   logic [9:0]  base_addr_i = '0;
   logic [9:0]  length_i = '0;
   logic [1:0]  op_i = '0;
   logic [7:0]  operand_i = '0;
   logic        run_i = 1'b0;
   logic        waitrequest_o;
   logic [9:0]  amm_rd_address_o;
   logic        amm_rd_read_o;
   logic [63:0] amm_rd_readdata_i = '0;
   logic        amm_rd_readdatavalid_i = 1'b0;
   logic        amm_rd_waitrequest_i = 1'b0;
   logic [9:0]  amm_wr_address_o;
   logic        amm_wr_write_o;
   logic [63:0] amm_wr_writedata_o;
   logic [7:0]  amm_wr_byteenable_o;
   logic        amm_wr_waitrequest_i = 1'b0;

   byte_proc u_dut (
      .clk_i                  (clk),
      .srst_i                 (srst_i),
      .base_addr_i            (base_addr_i),
      .length_i               (length_i),
      .op_i                   (op_i),
      .operand_i              (operand_i),
      .run_i                  (run_i),
      .waitrequest_o          (waitrequest_o),
      .amm_rd_address_o       (amm_rd_address_o),
      .amm_rd_read_o          (amm_rd_read_o),
      .amm_rd_readdata_i      (amm_rd_readdata_i),
      .amm_rd_readdatavalid_i (amm_rd_readdatavalid_i),
      .amm_rd_waitrequest_i   (amm_rd_waitrequest_i),
      .amm_wr_address_o       (amm_wr_address_o),
      .amm_wr_write_o         (amm_wr_write_o),
      .amm_wr_writedata_o     (amm_wr_writedata_o),
      .amm_wr_byteenable_o    (amm_wr_byteenable_o),
      .amm_wr_waitrequest_i   (amm_wr_waitrequest_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] base;
      logic [9:0] len;
      logic [1:0] op;
      logic [7:0] opd;
      bit         stall;
      bit         poke;
      int         abort;
      int         nw;
      logic [7:0] lbe;
   } vec_t;

   typedef struct {
      logic [9:0]  addr;
      logic [63:0] data;
      logic [7:0]  be;
   } wr_t;

   typedef struct {
      logic [9:0] addr;
      int         due;
   } rd_t;

   logic [63:0] mem [1024];
   wr_t         sb[$];
   rd_t         pend[$];
   vec_t        vecs[9];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          wr_count = 0;
   int          last_wr_cyc = 0;
   int          n_out = 0;
   int          max_out = 0;
   logic [7:0]  last_be = '0;
   logic [63:0] last_data = '0;
   bit          stall_en = 0;

   function automatic void chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endfunction

   function automatic logic [7:0] mop(input logic [7:0] b, input logic [7:0] x, input logic [1:0] o);
      int s;
      if (o == 2'd2) return b ^ x;
      if (o == 2'd3) return b;
      s = (o == 2'd0) ? int'(b) + int'(x) : int'(b) - int'(x);
`ifdef BYTE_PROC_SATURATE_EN
      if (s > 255) s = 255;
      if (s < 0) s = 0;
`endif
      return 8'(s & 255);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: random waitrequests, in-order read responses, write scoreboard
   always @(negedge clk) begin : responder
      wr_t e;
      logic [63:0] m;
      if (srst_i) begin
         pend.delete();
         sb.delete();
         n_out = 0;
         amm_rd_readdatavalid_i = 1'b0;
         amm_rd_waitrequest_i = 1'b0;
         amm_wr_waitrequest_i = 1'b0;
      end else begin
         amm_rd_readdatavalid_i = 1'b0;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            amm_rd_readdatavalid_i = 1'b1;
            amm_rd_readdata_i = mem[pend[0].addr];
            void'(pend.pop_front());
            n_out--;
         end
         amm_rd_waitrequest_i = stall_en && $urandom_range(0, 2) == 0;
         amm_wr_waitrequest_i = stall_en && $urandom_range(0, 2) == 0;
         if (amm_rd_read_o && !amm_rd_waitrequest_i) begin
            pend.push_back('{amm_rd_address_o, cyc + (stall_en ? int'($urandom_range(1, 5)) : 1)});
            n_out++;
            if (n_out > max_out) max_out = n_out;
         end
         if (amm_wr_write_o && !amm_wr_waitrequest_i) begin
            if (sb.size() == 0) chk(1'b0, "unexpected_wr", 64'(amm_wr_address_o), 64'(0));
            else begin
               e = sb.pop_front();
               m = '0;
               for (int k = 0; k < 8; k++) if (e.be[k]) m[8*k +: 8] = 8'hFF;
               chk(amm_wr_address_o == e.addr, "wr_addr", 64'(amm_wr_address_o), 64'(e.addr));
               chk((amm_wr_writedata_o & m) == (e.data & m), "wr_data", amm_wr_writedata_o & m, e.data & m);
               chk(amm_wr_byteenable_o == e.be, "wr_be", 64'(amm_wr_byteenable_o), 64'(e.be));
            end
            for (int k = 0; k < 8; k++)
               if (amm_wr_byteenable_o[k]) mem[amm_wr_address_o][8*k +: 8] = amm_wr_writedata_o[8*k +: 8];
            wr_count++;
            last_wr_cyc = cyc;
            last_be = amm_wr_byteenable_o;
            last_data = amm_wr_writedata_o;
         end
      end
   end

   task automatic chk_zero(input string nm);
      logic [30:0] ctl;
      ctl = {amm_rd_address_o, amm_rd_read_o, amm_wr_address_o, amm_wr_write_o, amm_wr_byteenable_o, waitrequest_o};
      chk(ctl == '0, {nm, "_ctl"}, 64'(ctl), 64'(0));
      chk(amm_wr_writedata_o == '0, {nm, "_data"}, amm_wr_writedata_o, 64'(0));
   endtask

   task automatic run_job(input vec_t v);
      int start;
      bit done;
      logic [9:0] a;
      logic [63:0] d;
      for (int i = 0; i < v.nw; i++) begin
         a = v.base + 10'(i);
         for (int k = 0; k < 8; k++) d[8*k +: 8] = mop(mem[a][8*k +: 8], v.opd, v.op);
         sb.push_back('{a, d, (i == v.nw - 1) ? v.lbe : 8'hFF});
      end
      stall_en = v.stall;
      start = wr_count;
      @(negedge clk);
      base_addr_i = v.base;
      length_i = v.len;
      op_i = v.op;
      operand_i = v.opd;
      run_i = 1'b1;
      @(negedge clk);
      run_i = 1'b0;
      chk(waitrequest_o == 1'b1, "busy", 64'(waitrequest_o), 64'(1));
      done = 0;
      for (int n = 0; n < 3000 && !done; n++) begin
         @(negedge clk);
         if (v.abort > 0 && wr_count - start >= v.abort) begin
            @(posedge clk);
            #2 srst_i = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk_zero("rst_mid");
            srst_i = 1'b0;
            return;
         end
         done = !waitrequest_o;
         run_i = v.poke && n == 2 && !done;
         if (run_i) begin
            base_addr_i = '0;
            length_i = 10'd8;
         end
      end
      chk(done, "timeout", 64'(done), 64'(1));
      chk(sb.size() == 0, "sb_drain", 64'(sb.size()), 64'(0));
      chk(wr_count - start == v.nw, "nwrites", 64'(wr_count - start), 64'(v.nw));
      chk(last_be == v.lbe, "last_be", 64'(last_be), 64'(v.lbe));
      chk(cyc - last_wr_cyc == 2, "wait_fall", 64'(cyc - last_wr_cyc), 64'(2));
      @(negedge clk);
      @(negedge clk);
      chk(waitrequest_o == 1'b0, "stay_idle", 64'(waitrequest_o), 64'(0));
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
      //         base     len     op    opd    stall poke abort nw  lbe
      vecs[0] = '{10'h010, 10'd21,  2'd0, 8'h01, 0, 0, 0, 3,  8'h1F};
      vecs[1] = '{10'h010, 10'd21,  2'd0, 8'h01, 1, 0, 0, 3,  8'h1F};
      vecs[2] = '{10'h3FC, 10'd45,  2'd0, 8'h03, 1, 0, 0, 4,  8'hFF};
      vecs[3] = '{10'h020, 10'd16,  2'd1, 8'h10, 1, 1, 0, 2,  8'hFF};
      vecs[4] = '{10'h030, 10'd16,  2'd2, 8'hA5, 1, 1, 0, 2,  8'hFF};
      vecs[5] = '{10'h100, 10'd100, 2'd3, 8'h00, 1, 0, 0, 13, 8'h0F};
      vecs[6] = '{10'h3FF, 10'd3,   2'd0, 8'hF0, 0, 0, 0, 1,  8'h07};
      vecs[7] = '{10'h3FE, 10'd20,  2'd1, 8'h01, 0, 0, 0, 2,  8'hFF};
      vecs[8] = '{10'h200, 10'd64,  2'd2, 8'hFF, 0, 0, 0, 8,  8'hFF};
      repeat (3) @(negedge clk);
      chk_zero("reset");
      srst_i = 1'b0;
      @(negedge clk);
      chk_zero("idle");
      for (int i = 0; i < 9; i++) run_job(vecs[i]);
      mem[10'h050] = 64'h2F1EFF16FF12FFEE;
      run_job('{10'h050, 10'd7, 2'd0, 8'h01, 0, 0, 0, 1, 8'h7F});
`ifdef BYTE_PROC_SATURATE_EN
      chk(last_data == 64'h301FFF17FF13FFEF, "sat_word", last_data, 64'h301FFF17FF13FFEF);
`else
      chk(last_data == 64'h301F0017001300EF, "wrap_word", last_data, 64'h301F0017001300EF);
`endif
      @(negedge clk);
      base_addr_i = 10'h005;
      length_i = '0;
      run_i = 1'b1;
      @(negedge clk);
      run_i = 1'b0;
      chk(waitrequest_o == 1'b0, "len0_a", 64'(waitrequest_o), 64'(0));
      @(negedge clk);
      chk(waitrequest_o == 1'b0, "len0_b", 64'(waitrequest_o), 64'(0));
      run_job('{10'h060, 10'd64, 2'd2, 8'h3C, 0, 0, 2, 8, 8'hFF});
      run_job('{10'h060, 10'd8, 2'd0, 8'h07, 0, 0, 0, 1, 8'hFF});
      chk(max_out <= 4, "max_outst", 64'(max_out), 64'(4));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
